// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter for the single write port of a shared fifo.
// Each grant latches one client word and issues a one-cycle write strobe with one cycle of setup and hold.
module fifo_wr_arbiter #(
  parameter  int NUM_REQ     = 4,
  parameter  int DATA_WIDTH  = 8,
  parameter  int SYNC_STAGES = 2,
  localparam int GW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk_i,
  input  logic                          n_reset_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
  output logic [NUM_REQ-1:0]            ack_o,
  output logic [GW-1:0]                 grant_o,
  output logic                          busy_o,
  output logic [DATA_WIDTH-1:0]         fifo_data_o,
  output logic                          fifo_wr_o,
  input  logic                          fifo_full_i
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RECOVER} state_e;

  localparam int              CW       = $clog2(SYNC_STAGES + 1);
  localparam logic [CW-1:0]   REC_LAST = CW'(SYNC_STAGES - 1);
  localparam logic [GW:0]     NR       = (GW + 1)'(NUM_REQ);
  localparam logic [GW-1:0]   LAST_RST = GW'(NUM_REQ - 1);

  state_e                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  full_sync_q;
  logic                    full_s;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [GW-1:0]           grant_q, grant_d;
  logic [GW-1:0]           last_q, last_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    wr_q, wr_d;
  logic [NUM_REQ-1:0]      ack_q, ack_d;

  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] data_a;
  logic                    pick_vld;
  logic [GW-1:0]           pick;

  assign data_a = data_i;

  always_ff @(posedge clk_i or negedge n_reset_i) begin
    if (!n_reset_i) full_sync_q <= '0;
    else            full_sync_q <= (full_sync_q << 1) | SYNC_STAGES'(fifo_full_i);
  end
  assign full_s = full_sync_q[SYNC_STAGES-1];

  // Scan from the farthest offset down so the nearest requester after last_q wins.
  always_comb begin
    logic [GW:0] idx;
    pick_vld = 1'b0;
    pick     = '0;
    idx      = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = {1'b0, last_q} + (GW + 1)'(i);
      if (idx >= NR) idx = idx - NR;
      if (req_i[idx[GW-1:0]]) begin
        pick_vld = 1'b1;
        pick     = idx[GW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    wr_d    = 1'b0;
    ack_d   = '0;
    case (state_q)
      IDLE: if (pick_vld && !full_s) begin
        state_d = SETUP;
        data_d  = data_a[pick];
        grant_d = pick;
        last_d  = pick;
      end
      SETUP: begin
        state_d = STROBE;
        wr_d    = 1'b1;
      end
      STROBE: begin
        state_d         = RECOVER;
        cnt_d           = REC_LAST;
        ack_d[grant_q]  = 1'b1;
      end
      RECOVER: begin
        // Lingering here lets full_s catch up with the word just written.
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge n_reset_i) begin
    if (!n_reset_i) begin
      state_q <= IDLE;
      data_q  <= '0;
      grant_q <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      ack_q   <= ack_d;
    end
  end

  assign ack_o       = ack_q;
  assign grant_o     = grant_q;
  assign busy_o      = (state_q != IDLE);
  assign fifo_data_o = data_q;
  assign fifo_wr_o   = wr_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized traffic against a
// transaction-age reference model and a small fifo model.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int S  = 2;
  localparam int GW = 2;

  logic           clk = 1'b0;
  logic           n_reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic [N-1:0]   ack;
  logic [GW-1:0]  grant;
  logic           busy;
  logic [W-1:0]   fdata;
  logic           fwr;
  logic           full;
  logic           full_drv, use_fifo, fifo_full_m, pop_req;

  int checks = 0;
  int errors = 0;

  assign full = use_fifo ? fifo_full_m : full_drv;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk_i(clk), .n_reset_i(n_reset), .req_i(req), .data_i(data),
    .ack_o(ack), .grant_o(grant), .busy_o(busy),
    .fifo_data_o(fdata), .fifo_wr_o(fwr), .fifo_full_i(full)
  );

  // Depth-8 fifo model: captures on each strobe, pops on request.
  logic [W-1:0] fq[$];
  int wr_count = 0;
  always @(posedge clk) begin
    if (pop_req && fq.size() > 0) void'(fq.pop_front());
    if (fwr) begin
      wr_count++;
      if (fq.size() < 8) fq.push_back(fdata);
    end
    fifo_full_m <= (fq.size() == 8);
  end

  // Reference: m_age counts clocks since the grant (-1 when no write is in flight).
  int           m_age, m_last, m_grant;
  logic [W-1:0] m_data;
  logic         m_fh[S];
  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      m_age = -1; m_last = N - 1; m_grant = 0; m_data = '0;
      for (int i = 0; i < S; i++) m_fh[i] = 1'b0;
    end else begin
      if (m_age < 0) begin
        if (!m_fh[S-1] && req != '0) begin
          bit found;
          found = 0;
          for (int off = 1; off <= N; off++) begin
            int k;
            k = (m_last + off) % N;
            if (!found && req[k]) begin
              found = 1; m_grant = k; m_last = k; m_data = data[k*W +: W];
            end
          end
          m_age = 1;
        end
      end else if (m_age == S + 2) m_age = -1;
      else m_age++;
      for (int i = S - 1; i > 0; i--) m_fh[i] = m_fh[i-1];
      m_fh[0] = full;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    n_reset = 1'b0;
    @(negedge clk);
    n_reset = 1'b1;
  endtask

  task automatic test_reset();
    n_reset = 1'b0; req = '0; data = '0; full_drv = 1'b0; use_fifo = 1'b0; pop_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (fwr !== 1'b0)   begin errors++; $display("FAIL reset_wr got %b exp 0", fwr); end
    checks++; if (ack !== '0)     begin errors++; $display("FAIL reset_ack got %b exp 0", ack); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (fdata !== '0)   begin errors++; $display("FAIL reset_data got %h exp 00", fdata); end
    checks++; if (grant !== '0)   begin errors++; $display("FAIL reset_grant got %0d exp 0", grant); end
    n_reset = 1'b1;
  endtask

  task automatic test_single();
    logic [4:0] e_wr, e_busy, e_ack;
    e_wr = 5'b00010; e_ack = 5'b00100; e_busy = 5'b01111;
    @(negedge clk);
    req = 4'b0001; data[0 +: W] = 8'hA5;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (fwr !== e_wr[c]) begin errors++; $display("FAIL single_wr c%0d got %b exp %b", c, fwr, e_wr[c]); end
      checks++; if (ack !== (e_ack[c] ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL single_ack c%0d got %b exp %b", c, ack, e_ack[c]); end
      checks++; if (busy !== e_busy[c]) begin errors++; $display("FAIL single_busy c%0d got %b exp %b", c, busy, e_busy[c]); end
      if (c < 4) begin
        checks++; if (fdata !== 8'hA5) begin errors++; $display("FAIL single_data c%0d got %h exp a5", c, fdata); end
      end
      if (ack[0]) req = '0;
    end
  endtask

  task automatic test_round_robin();
    int wc[$]; logic [W-1:0] wd[$]; int ai[$];
    @(negedge clk);
    n_reset = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < N; k++) data[k*W +: W] = 8'h10 + W'(k);
    @(negedge clk);
    n_reset = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (fwr) begin wc.push_back(c); wd.push_back(fdata); end
      for (int k = 0; k < N; k++) if (ack[k]) ai.push_back(k);
    end
    req = '0;
    checks++; if (wd.size() != 5) begin errors++; $display("FAIL rr_count got %0d exp 5", wd.size()); end
    for (int i = 0; i < wd.size() && i < 5; i++) begin
      checks++; if (wd[i] !== 8'h10 + W'(i % N)) begin errors++; $display("FAIL rr_data %0d got %h exp %h", i, wd[i], 8'h10 + W'(i % N)); end
      if (i > 0) begin
        checks++; if (wc[i] - wc[i-1] != 3 + S) begin errors++; $display("FAIL rr_period %0d got %0d exp %0d", i, wc[i] - wc[i-1], 3 + S); end
      end
    end
    for (int i = 0; i < ai.size() && i < 5; i++) begin
      checks++; if (ai[i] != i % N) begin errors++; $display("FAIL rr_ack %0d got %0d exp %0d", i, ai[i], i % N); end
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_full();
    full_drv = 1'b1;
    repeat (3) @(negedge clk);
    req = 4'b0010; data[1*W +: W] = 8'h77;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++; if (fwr !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL full_hold c%0d got wr%b busy%b exp 0 0", c, fwr, busy); end
    end
    full_drv = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++; if (fwr !== (k == 4)) begin errors++; $display("FAIL full_release k%0d got %b exp %b", k, fwr, k == 4); end
      if (ack[1]) req = '0;
    end
    checks++; if (req !== '0) begin errors++; $display("FAIL full_ack got req %b exp 0000", req); end
    req = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_fifo();
    logic [W-1:0] nxt;
    @(negedge clk);
    n_reset = 1'b0; fq.delete(); use_fifo = 1'b1; wr_count = 0;
    req = 4'b0001; data[0 +: W] = 8'h40; nxt = 8'h41;
    @(negedge clk);
    n_reset = 1'b1; wr_count = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (ack[0]) begin data[0 +: W] = nxt; nxt++; end
    end
    checks++; if (wr_count != 8) begin errors++; $display("FAIL fifo_fill_count got %0d exp 8", wr_count); end
    for (int i = 0; i < 8 && i < fq.size(); i++) begin
      checks++; if (fq[i] !== 8'h40 + W'(i)) begin errors++; $display("FAIL fifo_fill_word %0d got %h exp %h", i, fq[i], 8'h40 + W'(i)); end
    end
    pop_req = 1'b1;
    @(negedge clk);
    pop_req = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ack[0]) begin data[0 +: W] = nxt; nxt++; end
    end
    checks++; if (wr_count != 9) begin errors++; $display("FAIL fifo_pop_count got %0d exp 9", wr_count); end
    checks++; if (fq.size() != 8) begin errors++; $display("FAIL fifo_pop_size got %0d exp 8", fq.size()); end
    for (int i = 0; i < 8 && i < fq.size(); i++) begin
      checks++; if (fq[i] !== 8'h41 + W'(i)) begin errors++; $display("FAIL fifo_pop_word %0d got %h exp %h", i, fq[i], 8'h41 + W'(i)); end
    end
    req = '0;
    repeat (6) @(negedge clk);
    use_fifo = 1'b0; fq.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_drop_req();
    @(negedge clk);
    req = 4'b0100; data[2*W +: W] = 8'h5C;
    @(negedge clk);
    checks++; if (busy !== 1'b1 || grant !== 2'd2) begin errors++; $display("FAIL drop_grant got busy%b g%0d exp 1 2", busy, grant); end
    req = '0; data[2*W +: W] = 8'hFF;
    @(negedge clk);
    checks++; if (fwr !== 1'b1 || fdata !== 8'h5C) begin errors++; $display("FAIL drop_write got wr%b %h exp 1 5c", fwr, fdata); end
    @(negedge clk);
    checks++; if (ack !== 4'b0100 || fdata !== 8'h5C) begin errors++; $display("FAIL drop_ack got %b %h exp 0100 5c", ack, fdata); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 0;
    @(negedge clk);
    req = 4'b0001; data[0 +: W] = 8'h33;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (fwr) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL midrst_strobe got none exp strobe"); end
    #2 n_reset = 1'b0;
    #1;
    checks++; if (fwr !== 1'b0)  begin errors++; $display("FAIL midrst_wr got %b exp 0", fwr); end
    checks++; if (ack !== '0)    begin errors++; $display("FAIL midrst_ack got %b exp 0", ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
    req = 4'b1111;
    for (int k = 0; k < N; k++) data[k*W +: W] = 8'h10 + W'(k);
    @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    checks++; if (grant !== 2'd0 || busy !== 1'b1 || fdata !== 8'h10) begin
      errors++; $display("FAIL midrst_first got g%0d busy%b %h exp 0 1 10", grant, busy, fdata);
    end
    req = '0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_random();
    logic [N-1:0] ea;
    do_reset();
    full_drv = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      ea = (m_age == 3) ? (N'(1) << m_grant) : '0;
      checks++;
      if (fwr !== (m_age == 2) || ack !== ea || busy !== (m_age >= 1) || fdata !== m_data || grant !== GW'(m_grant)) begin
        errors++;
        $display("FAIL random c%0d got wr%b ack%b busy%b d%h g%0d exp wr%b ack%b busy%b d%h g%0d",
                 c, fwr, ack, busy, fdata, grant, m_age == 2, ea, m_age >= 1, m_data, m_grant);
      end
      for (int k = 0; k < N; k++) begin
        if (req[k] && ack[k]) begin
          if ($urandom_range(1, 0) == 1) req[k] = 1'b0;
          else data[k*W +: W] = W'($urandom);
        end else if (!req[k] && $urandom_range(3, 0) == 0) begin
          req[k] = 1'b1; data[k*W +: W] = W'($urandom);
        end
      end
      if ($urandom_range(15, 0) == 0) full_drv = ~full_drv;
    end
    req = '0; full_drv = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_fifo();
    test_drop_req();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
